// File: rtl/arcade_input_conditioner.sv
// Control conditioning for the arcade cores: 2-FF sync + debounce per channel, coin pulse
// stretcher and vsync-committed video-mode sequencer. Define AUTOFIRE_EN to add autofire.
module arcade_input_conditioner #(
    parameter int                  CHANNELS          = 11,
    parameter int                  DEB_CYCLES        = 16,
    parameter int                  COIN_PULSE_CYCLES = 8,
    parameter int                  NUM_MODES         = 2,
    parameter int                  RESET_MODE        = 1,
    parameter logic [CHANNELS-1:0] AUTOFIRE_MASK     = '0,
    parameter int                  AUTOFIRE_DIV      = 4096
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [CHANNELS-1:0] ctrl_n_i,
    input  logic                mode_req_i,
    input  logic                vsync_i,
    input  logic                autofire_en_i,
    output logic [CHANNELS-1:0] ctrl_o,
    output logic                coin_o,
    output logic [2:0]          mode_o,
    output logic                scandoubler_disable_o,
    output logic [1:0]          scanlines_o
);
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int COIN_W = $clog2(COIN_PULSE_CYCLES + 1);

    logic [CHANNELS-1:0] r_sync_p0, r_sync_p1;
    logic [CHANNELS-1:0] r_deb_state;
    logic [DEB_W-1:0]    r_deb_cnt [CHANNELS];
    logic [CHANNELS-1:0] w_diff, w_deb_next;
    logic [COIN_W-1:0]   r_coin_cnt;
    logic                r_coin;
    logic                w_coin_rise;
    logic                r_vsync_d, r_req_d, r_pending;
    logic [2:0]          r_mode;
    logic                w_vs_edge, w_req_edge;

    // Stage 0/1: synchroniser, idles at the released (high) level
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sync_p0 <= '1;
            r_sync_p1 <= '1;
        end else begin
            r_sync_p0 <= ctrl_n_i;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Stage 2: debounce; state flips once the counter has already reached DEB_CYCLES
    always_comb begin
        w_diff     = '0;
        w_deb_next = r_deb_state;
        for (int i = 0; i < CHANNELS; i++) begin
            w_diff[i] = (~r_sync_p1[i]) != r_deb_state[i];
            if (w_diff[i] && (r_deb_cnt[i] == DEB_W'(DEB_CYCLES)))
                w_deb_next[i] = ~r_sync_p1[i];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_deb_state <= '0;
            for (int i = 0; i < CHANNELS; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_deb_state <= w_deb_next;
            for (int i = 0; i < CHANNELS; i++) begin
                if (!w_diff[i] || (r_deb_cnt[i] == DEB_W'(DEB_CYCLES)))
                    r_deb_cnt[i] <= '0;
                else
                    r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
            end
        end
    end

    // Coin pulse is launched from the same edge that updates the debounced coin level
    assign w_coin_rise = w_deb_next[0] & ~r_deb_state[0];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_coin_cnt <= '0;
            r_coin     <= 1'b0;
        end else if (w_coin_rise && (r_coin_cnt == '0)) begin
            r_coin_cnt <= COIN_W'(COIN_PULSE_CYCLES);
            r_coin     <= 1'b1;
        end else if (r_coin_cnt != '0) begin
            r_coin_cnt <= r_coin_cnt - COIN_W'(1);
            r_coin     <= (r_coin_cnt != COIN_W'(1));
        end else begin
            r_coin     <= 1'b0;
        end
    end

    assign w_vs_edge  = vsync_i & ~r_vsync_d;
    assign w_req_edge = mode_req_i & ~r_req_d;

    // Mode steps at most once per frame, committed on the vsync rising edge
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_vsync_d <= 1'b0;
            r_req_d   <= 1'b0;
            r_pending <= 1'b0;
            r_mode    <= 3'(RESET_MODE);
        end else begin
            r_vsync_d <= vsync_i;
            r_req_d   <= mode_req_i;
            if (w_vs_edge && (r_pending || w_req_edge)) begin
                r_mode    <= (r_mode == 3'(NUM_MODES - 1)) ? 3'd0 : r_mode + 3'd1;
                r_pending <= 1'b0;
            end else if (w_req_edge) begin
                r_pending <= 1'b1;
            end
        end
    end

`ifdef AUTOFIRE_EN
    localparam int                  AF_W    = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
    localparam logic [CHANNELS-1:0] AF_MASK = AUTOFIRE_MASK & ~CHANNELS'(1);

    logic [AF_W-1:0]     r_af_cnt [CHANNELS];
    logic [CHANNELS-1:0] r_af_phase;
    logic [CHANNELS-1:0] r_ctrl;

    // Stage 3: autofire gate; phase 0 (high) is always the first half-period of a burst
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_ctrl     <= '0;
            r_af_phase <= '0;
            for (int i = 0; i < CHANNELS; i++) r_af_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (AF_MASK[i] && autofire_en_i && w_deb_next[i]) begin
                    r_ctrl[i] <= ~r_af_phase[i];
                    if (r_af_cnt[i] == AF_W'(AUTOFIRE_DIV - 1)) begin
                        r_af_cnt[i]   <= '0;
                        r_af_phase[i] <= ~r_af_phase[i];
                    end else begin
                        r_af_cnt[i]   <= r_af_cnt[i] + AF_W'(1);
                    end
                end else begin
                    r_ctrl[i]     <= w_deb_next[i];
                    r_af_cnt[i]   <= '0;
                    r_af_phase[i] <= 1'b0;
                end
            end
        end
    end

    assign ctrl_o = r_ctrl;
`else
    logic w_unused_af;
    assign w_unused_af = autofire_en_i ^ (|AUTOFIRE_MASK) ^ (AUTOFIRE_DIV == 0);
    assign ctrl_o      = r_deb_state;
`endif

    assign coin_o                = r_coin;
    assign mode_o                = r_mode;
    assign scandoubler_disable_o = (r_mode == 3'd1);
    assign scanlines_o           = (r_mode >= 3'd2) ? 2'(r_mode - 3'd1) : 2'd0;

endmodule
